otter_cache_ctrl: RTL and testbench

- Miss-handling FSM for the OTTER data cache: direct-mapped, write-back, write-allocate.
- Sits between the pipeline MEM stage, the cache tag/data arrays, and the main-memory port.
- On a miss, stalls the pipeline, writes back a dirty victim line, fills the new line word by word, then releases the stall.
- Tag compare is external; this block only sequences the arrays and the memory port.

---
 rtl/otter_cache_ctrl.sv | 129 ++++++++++++
 tb/tb_otter_cache_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/otter_cache_ctrl.sv
// Miss-handling sequencer for the OTTER direct-mapped, write-back, write-allocate data cache.
// Stalls the pipeline on a miss, writes back a dirty victim, fills the line, then re-looks-up.
module otter_cache_ctrl #(
    parameter int unsigned WORDS_PER_LINE = 4,
    parameter int unsigned IDX_W          = $clog2(WORDS_PER_LINE),
    parameter int unsigned CNT_W          = 16
) (
    input  logic             CC_CLK,
    input  logic             CC_RESET_N,
    input  logic             CC_REQ,
    input  logic             CC_WE,
    input  logic             CC_HIT,
    input  logic             CC_DIRTY,
    input  logic             CC_MEM_ACK,
    output logic             CC_STALL,
    output logic             CC_MEM_RD,
    output logic             CC_MEM_WR,
    output logic             CC_SEL_VICTIM,
    output logic [IDX_W-1:0] CC_WORD_IDX,
    output logic             CC_LINE_WE,
    output logic             CC_TAG_WE,
    output logic             CC_SET_DIRTY,
    output logic [CNT_W-1:0] CC_MISS_CNT
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WB   = 2'd1;
    localparam logic [1:0] S_FILL = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [IDX_W-1:0] LAST_BEAT = IDX_W'(WORDS_PER_LINE - 1);

    logic [1:0]       state_q, state_d;
    logic [IDX_W-1:0] beat_q, beat_d;
    logic [CNT_W-1:0] miss_q, miss_d;

    logic             stall, mem_rd, mem_wr, sel_victim, line_we, tag_we, set_dirty;
    logic [IDX_W-1:0] word_idx;

    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        miss_d     = miss_q;
        stall      = 1'b0;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        sel_victim = 1'b0;
        line_we    = 1'b0;
        tag_we     = 1'b0;
        set_dirty  = 1'b0;
        word_idx   = '0;

        case (state_q)
            S_IDLE: begin
                if (CC_REQ) begin
                    if (CC_HIT) begin
                        set_dirty = CC_WE;
                    end else begin
                        stall   = 1'b1;
                        beat_d  = '0;
                        if (miss_q != '1) begin
                            miss_d = miss_q + 1'b1;
                        end
                        state_d = CC_DIRTY ? S_WB : S_FILL;
                    end
                end
            end
            S_WB: begin
                stall      = 1'b1;
                mem_wr     = 1'b1;
                sel_victim = 1'b1;
                word_idx   = beat_q;
                if (CC_MEM_ACK) begin
                    if (beat_q == LAST_BEAT) begin
                        beat_d  = '0;
                        state_d = S_FILL;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            S_FILL: begin
                stall    = 1'b1;
                mem_rd   = 1'b1;
                word_idx = beat_q;
                line_we  = CC_MEM_ACK;
                if (CC_MEM_ACK) begin
                    if (beat_q == LAST_BEAT) begin
                        tag_we  = 1'b1;
                        beat_d  = '0;
                        state_d = S_DONE;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            S_DONE: begin
                // Arrays re-read the freshly filled line before the request is retried.
                stall   = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CC_CLK) begin
        if (!CC_RESET_N) begin
            state_q <= S_IDLE;
            beat_q  <= '0;
            miss_q  <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            miss_q  <= miss_d;
        end
    end

    // Reset masks every output immediately, not just from the next edge.
    assign CC_STALL      = CC_RESET_N & stall;
    assign CC_MEM_RD     = CC_RESET_N & mem_rd;
    assign CC_MEM_WR     = CC_RESET_N & mem_wr;
    assign CC_SEL_VICTIM = CC_RESET_N & sel_victim;
    assign CC_LINE_WE    = CC_RESET_N & line_we;
    assign CC_TAG_WE     = CC_RESET_N & tag_we;
    assign CC_SET_DIRTY  = CC_RESET_N & set_dirty;
    assign CC_WORD_IDX   = CC_RESET_N ? word_idx : '0;
    assign CC_MISS_CNT   = CC_RESET_N ? miss_q : '0;

endmodule

// File: tb/tb_otter_cache_ctrl.sv
// Directed bench for otter_cache_ctrl: a beat-counting reference model checked every cycle,
// plus literal stall/beat/count expectations per scenario.
module tb_otter_cache_ctrl;

    localparam int WPL = 4;

    logic clk = 1'b0;
    logic rst_n, req, we, hit, dirty, ack;

    logic       stall, mem_rd, mem_wr, sel_v, line_we, tag_we, set_dirty;
    logic [1:0] idx;
    logic [15:0] mcnt;

    logic       s_stall, s_rd, s_wr, s_sel, s_lwe, s_twe, s_sd;
    logic [1:0] s_idx;
    logic [1:0] s_mcnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    otter_cache_ctrl #(.WORDS_PER_LINE(WPL), .CNT_W(16)) dut (
        .CC_CLK(clk), .CC_RESET_N(rst_n), .CC_REQ(req), .CC_WE(we), .CC_HIT(hit),
        .CC_DIRTY(dirty), .CC_MEM_ACK(ack), .CC_STALL(stall), .CC_MEM_RD(mem_rd),
        .CC_MEM_WR(mem_wr), .CC_SEL_VICTIM(sel_v), .CC_WORD_IDX(idx), .CC_LINE_WE(line_we),
        .CC_TAG_WE(tag_we), .CC_SET_DIRTY(set_dirty), .CC_MISS_CNT(mcnt)
    );

    otter_cache_ctrl #(.WORDS_PER_LINE(WPL), .CNT_W(2)) dut_sat (
        .CC_CLK(clk), .CC_RESET_N(rst_n), .CC_REQ(req), .CC_WE(we), .CC_HIT(hit),
        .CC_DIRTY(dirty), .CC_MEM_ACK(ack), .CC_STALL(s_stall), .CC_MEM_RD(s_rd),
        .CC_MEM_WR(s_wr), .CC_SEL_VICTIM(s_sel), .CC_WORD_IDX(s_idx), .CC_LINE_WE(s_lwe),
        .CC_TAG_WE(s_twe), .CC_SET_DIRTY(s_sd), .CC_MISS_CNT(s_mcnt)
    );

    task automatic chk(input string nm, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: outstanding write-back beats, outstanding fill beats, pending re-lookup.
    int          m_wb_left   = 0;
    int          m_fill_left = 0;
    bit          m_done      = 0;
    longint      m_misses    = 0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_wb_left = 0; m_fill_left = 0; m_done = 0; m_misses = 0;
        end else if (m_wb_left > 0) begin
            if (ack) m_wb_left--;
        end else if (m_fill_left > 0) begin
            if (ack) begin
                m_fill_left--;
                if (m_fill_left == 0) m_done = 1;
            end
        end else if (m_done) begin
            m_done = 0;
        end else if (req && !hit) begin
            m_misses++;
            m_fill_left = WPL;
            m_wb_left   = dirty ? WPL : 0;
        end
    end

    always @(negedge clk) begin
        longint e_stall, e_rd, e_wr, e_sel, e_idx, e_lwe, e_twe, e_sd, e_mc, e_mc2;
        e_stall = 0; e_rd = 0; e_wr = 0; e_sel = 0; e_idx = 0;
        e_lwe = 0; e_twe = 0; e_sd = 0; e_mc = 0; e_mc2 = 0;
        if (rst_n === 1'b1) begin
            if (m_wb_left > 0) begin
                e_stall = 1; e_wr = 1; e_sel = 1; e_idx = WPL - m_wb_left;
            end else if (m_fill_left > 0) begin
                e_stall = 1; e_rd = 1; e_idx = WPL - m_fill_left;
                e_lwe = ack; e_twe = (ack && m_fill_left == 1) ? 1 : 0;
            end else if (m_done) begin
                e_stall = 1;
            end else if (req) begin
                if (hit) e_sd = we;
                else     e_stall = 1;
            end
            e_mc  = (m_misses > 65535) ? 65535 : m_misses;
            e_mc2 = (m_misses > 3) ? 3 : m_misses;
        end
        chk("stall", stall, e_stall);
        chk("mem_rd", mem_rd, e_rd);
        chk("mem_wr", mem_wr, e_wr);
        chk("sel_victim", sel_v, e_sel);
        chk("word_idx", idx, e_idx);
        chk("line_we", line_we, e_lwe);
        chk("tag_we", tag_we, e_twe);
        chk("set_dirty", set_dirty, e_sd);
        chk("miss_cnt", mcnt, e_mc);
        chk("miss_cnt_sat", s_mcnt, e_mc2);
        chk("stall_sat", s_stall, e_stall);
    end

    // One miss from detect through the retried hit; hit is raised after the detect cycle
    // since the pipeline holds the request and the line is valid once filled.
    task automatic run_miss(input bit w, input bit d, input int per,
                            output int st, output int rd, output int wr, output int tg,
                            output int sd);
        bit fin;
        st = 0; rd = 0; wr = 0; tg = 0; sd = -1; fin = 0;
        for (int k = 0; k < 200 && !fin; k++) begin
            @(posedge clk); #1;
            req = 1; we = w;
            if (k == 0) begin
                hit = 0; dirty = d; ack = 0;
            end else begin
                hit = 1; dirty = 0;
                ack = (per == 1) ? 1'b1 : ((k % 2) == 0);
            end
            @(negedge clk);
            if (stall) st++;
            else begin
                fin = 1; sd = set_dirty;
            end
            rd += int'(mem_rd); wr += int'(mem_wr); tg += int'(tag_we);
        end
        if (!fin) chk("miss_timeout", 0, 1);
        @(posedge clk); #1;
        req = 0; we = 0; hit = 0; ack = 0; dirty = 0;
    endtask

    initial begin
        int st, rd, wr, tg, sd, tg_abort;
        int sat_exp [5] = '{1, 2, 3, 3, 3};

        rst_n = 0; req = 1; we = 0; hit = 0; dirty = 0; ack = 1;
        repeat (2) begin
            @(negedge clk);
            chk("rst_stall", stall, 0);
            chk("rst_mem_rd", mem_rd, 0);
            chk("rst_miss_cnt", mcnt, 0);
        end

        @(posedge clk); #1;
        rst_n = 1; req = 1; hit = 1; we = 0; ack = 0;
        @(negedge clk);
        chk("load_hit_stall", stall, 0);
        chk("load_hit_set_dirty", set_dirty, 0);
        @(posedge clk); #1;
        we = 1;
        @(negedge clk);
        chk("store_hit_stall", stall, 0);
        chk("store_hit_set_dirty", set_dirty, 1);
        chk("store_hit_mem", mem_rd | mem_wr, 0);
        @(posedge clk); #1;
        req = 0; we = 0; hit = 0;

        run_miss(0, 0, 1, st, rd, wr, tg, sd);
        chk("clean_stall_cycles", st, 6);
        chk("clean_rd_beats", rd, 4);
        chk("clean_wr_beats", wr, 0);
        chk("clean_tag_we", tg, 1);
        chk("clean_miss_cnt", mcnt, 1);

        run_miss(1, 1, 2, st, rd, wr, tg, sd);
        chk("dirty_slow_stall_cycles", st, 18);
        chk("dirty_slow_wr_cycles", wr, 8);
        chk("dirty_slow_rd_cycles", rd, 8);
        chk("dirty_slow_tag_we", tg, 1);
        chk("dirty_slow_set_dirty", sd, 1);
        chk("dirty_slow_miss_cnt", mcnt, 2);

        run_miss(0, 1, 1, st, rd, wr, tg, sd);
        chk("dirty_fast_stall_cycles", st, 10);

        tg_abort = 0;
        @(posedge clk); #1;
        req = 1; hit = 0; dirty = 0; ack = 1;
        @(negedge clk); tg_abort += int'(tag_we);
        repeat (2) begin
            @(posedge clk); #1; hit = 1;
            @(negedge clk); tg_abort += int'(tag_we);
        end
        @(posedge clk); #1;
        rst_n = 0;
        @(negedge clk); tg_abort += int'(tag_we);
        chk("abort_rst_stall", stall, 0);
        @(posedge clk); #1;
        rst_n = 1; req = 0; hit = 0; ack = 0;
        @(negedge clk); tg_abort += int'(tag_we);
        chk("abort_no_tag_we", tg_abort, 0);
        chk("abort_word_idx", idx, 0);
        chk("abort_idle_stall", stall, 0);
        run_miss(0, 0, 1, st, rd, wr, tg, sd);
        chk("restart_stall_cycles", st, 6);
        chk("restart_rd_beats", rd, 4);

        @(posedge clk); #1; rst_n = 0;
        @(posedge clk); #1; rst_n = 1;
        for (int i = 0; i < 5; i++) begin
            run_miss(0, 0, 1, st, rd, wr, tg, sd);
            chk("sat_miss_cnt", s_mcnt, sat_exp[i]);
        end
        chk("wide_miss_cnt", mcnt, 5);

        @(negedge clk); #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
